// File: rtl/seq_det_scheduler.sv
// Round-robin time-shared "1011" overlapping sequence detector for NCH serial requesters.
// Keeps per-channel detector state and saturating match counters; one bit processed per cycle.
//
// state | meaning
// S0    | no progress
// S1    | seen "1"
// S2    | seen "10"
// S3    | seen "101" (a following 1 completes a match)
module seq_det_scheduler #(
    parameter int NCH  = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req_valid,
    input  logic [NCH-1:0]  req_bit,
    output logic [NCH-1:0]  req_ready,
    input  logic [NCH-1:0]  clr_ch,
    output logic            det_valid,
    output logic [IDW-1:0]  det_id,
    output logic            det_match,
    input  logic [IDW-1:0]  rd_sel,
    output logic [CNTW-1:0] rd_cnt
);

    typedef enum logic [1:0] {S0, S1, S2, S3} det_state_t;

    det_state_t      state_tbl [NCH];
    logic [CNTW-1:0] cnt_tbl   [NCH];
    logic [IDW-1:0]  ptr;

    logic [NCH-1:0]   elig;
    logic [2*NCH-1:0] elig_dbl;
    logic [NCH-1:0]   elig_rot;
    logic             found;
    int               gsum;
    logic [IDW-1:0]   gidx;
    det_state_t       cur_state;
    det_state_t       nxt_state;
    logic             cur_bit;
    logic             match;

    // Rotate eligibility so bit 0 is the pointer's channel; lowest set bit wins.
    always_comb begin
        elig     = req_valid & ~clr_ch;
        elig_dbl = {elig, elig} >> ptr;
        elig_rot = elig_dbl[NCH-1:0];
        found    = 1'b0;
        gsum     = int'(ptr);
        for (int k = NCH - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                found = 1'b1;
                gsum  = int'(ptr) + k;
            end
        end
        if (gsum >= NCH) gsum = gsum - NCH;
        gidx = IDW'(gsum);
        if (rst) found = 1'b0;
    end

    // Next-state logic for the single shared detector core.
    always_comb begin
        cur_state = S0;
        cur_bit   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (gidx == IDW'(i)) begin
                cur_state = state_tbl[i];
                cur_bit   = req_bit[i];
            end
        end
        nxt_state = cur_state;
        match     = 1'b0;
        case (cur_state)
            S0: nxt_state = cur_bit ? S1 : S0;
            S1: nxt_state = cur_bit ? S1 : S2;
            S2: nxt_state = cur_bit ? S3 : S0;
            S3: begin
                nxt_state = cur_bit ? S1 : S2;
                match     = cur_bit;
            end
            default: nxt_state = S0;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rd_cnt    = '0;
        for (int i = 0; i < NCH; i++) begin
            req_ready[i] = found && (gidx == IDW'(i));
            if (rd_sel == IDW'(i)) rd_cnt = cnt_tbl[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_tbl[i] <= S0;
                cnt_tbl[i]   <= '0;
            end
            ptr       <= '0;
            det_valid <= 1'b0;
            det_id    <= '0;
            det_match <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr_ch[i]) begin
                    state_tbl[i] <= S0;
                    cnt_tbl[i]   <= '0;
                end else if (req_ready[i]) begin
                    state_tbl[i] <= nxt_state;
                    if (match && cnt_tbl[i] != '1) cnt_tbl[i] <= cnt_tbl[i] + 1'b1;
                end
            end
            det_valid <= found;
            if (found) begin
                det_id    <= gidx;
                det_match <= match;
                ptr       <= (gidx == IDW'(NCH - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
- Time-shares a single overlapping "1011" serial sequence-detector core between NCH independent serial-bit requesters.
- Arbitrates round-robin and accepts at most one bit per cycle.
- Keeps a per-channel 2-bit detector state table and per-channel saturating match counters.
- Reports each processed bit as a registered result tagged with its channel id.
- Sits between the serial input front-ends and the match-event consumer.

Parameters:
- NCH, 4, number of requester channels (2..16).
- IDW, 2, channel id width; must satisfy 2^IDW >= NCH.
- CNTW, 8, width of each per-channel match counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NCH  channel i presents a bit on req_bit[i].
- req_bit  in  NCH  serial data bit for channel i.
- req_ready  out  NCH  one-hot-or-zero grant; bit i is consumed when req_valid[i] & req_ready[i].
- clr_ch  in  NCH  clears channel i's detector state and match counter.
- det_valid  out  1  registered: a bit was processed in the previous cycle.
- det_id  out  IDW  registered: channel of the processed bit.
- det_match  out  1  registered: the processed bit completed "1011".
- rd_sel  in  IDW  counter read select.
- rd_cnt  out  CNTW  combinational read of match counter[rd_sel]; 0 if rd_sel >= NCH.

Behaviour:
- Reset (rst=1 at an edge):
  - all state table entries become S0; all counters become 0.
  - round-robin pointer becomes 0.
  - det_valid, det_id and det_match become 0.
  - req_ready is 0 combinationally while rst=1.
- Detector states per channel:
  - S0 means no progress; S1 means seen "1"; S2 means seen "10"; S3 means seen "101".
  - S0: bit 0 -> S0; bit 1 -> S1.
  - S1: bit 0 -> S2; bit 1 -> S1.
  - S2: bit 0 -> S0; bit 1 -> S3.
  - S3: bit 0 -> S2; bit 1 -> S1 with match=1. Detection overlaps.
- Arbitration (combinational):
  - Eligible channels are those with req_valid[i]=1 and clr_ch[i]=0.
  - The grant goes to the first eligible channel searching upward, with wrap, from the pointer.
  - req_ready has exactly that bit set, or is all zero if nothing is eligible.
  - On a transfer, the pointer becomes (granted+1) mod NCH. It is unchanged otherwise.
- Processing of a transfer on channel g at edge T:
  - state[g] updates per the table.
  - counter[g] increments on a match, saturating at 2^CNTW-1.
  - At T, det_valid=1, det_id=g and det_match=match are registered, visible in cycle T+1. Latency is 1 cycle.
  - With no transfer, det_valid=0 next cycle; det_id and det_match hold their previous values.
- Requester rule: while req_valid[i]=1 and req_ready[i]=0, the requester holds req_bit[i] stable and does not drop req_valid. The block does not check this.
- Clear:
  - clr_ch[i]=1 at an edge sets state[i]=S0 and counter[i]=0.
  - That channel is not granted in that cycle.
  - Other channels proceed normally in the same cycle.
  - Multiple clears in one cycle are allowed.
- rd_cnt reflects register contents. The same-edge increment is visible in the following cycle.
- Channel states are fully independent; interleaving between channels never affects a channel's detection result.
- Reset asserted mid-stream drops the in-flight result: det_valid=0 after the reset edge, and all progress is lost.

Test Plan:
- Single channel 0 streams 1,0,1,1,0,1,1 back-to-back, others idle:
  - req_ready[0]=1 every cycle.
  - det_match=1 for the 4th and 7th bits (overlap), each 1 cycle after acceptance.
  - rd_sel=0 gives rd_cnt=2.
- All 4 channels valid continuously:
  - grants go 0,1,2,3,0,... one per cycle.
  - channel 2 fed 1,0,1,1 across its grants gets det_match=1 with det_id=2 only on its 4th grant.
- Channel 1 sends 1,0,1, then clr_ch[1]=1 for one cycle, then sends 1:
  - no match.
  - counter[1]=0.
  - req_ready[1]=0 during the clear cycle.
- CNTW=2, channel 3 sends "1011" repeated as 1,0,1,1,0,1,1,0,1,1,0,1,1 (4 matches): rd_cnt saturates at 3.
- Reset asserted for 1 cycle between bits 3 and 4 of "1011" on channel 0:
  - det_valid=0 after the reset.
  - the subsequent single 1 produces no match.
- rd_sel=5 with NCH=4 gives rd_cnt=0. req_valid=0 on all channels gives req_ready=0 and det_valid=0.
